// File: rtl/counter_run_ctrl_if.sv
// Button, datapath and control bundle for the counter run-control sequencer.
// The master side owns the buttons, the limit and the counter readback.
// The slave side is the sequencer, which drives the counter controls and status.
interface counter_run_ctrl_if;
  logic       start_btn;
  logic       stop_btn;
  logic       step_btn;
  logic       clear_btn;
  logic [3:0] limit;
  logic [3:0] count_in;
  logic       cnt_en;
  logic       cnt_clr;
  logic       busy;
  logic       done;
  logic       step_err;
  logic [1:0] state;

  modport master (
    output start_btn, stop_btn, step_btn, clear_btn, limit, count_in,
    input  cnt_en, cnt_clr, busy, done, step_err, state
  );

  modport slave (
    input  start_btn, stop_btn, step_btn, clear_btn, limit, count_in,
    output cnt_en, cnt_clr, busy, done, step_err, state
  );
endinterface

// File: rtl/counter_run_ctrl.sv
// Run-control sequencer for the 4-bit LED tick counter.
// Turns start/stop/step/clear buttons into counter enable and clear controls,
// auto-stops at a programmable limit, and guards single-step with a watchdog.
module counter_run_ctrl #(
  parameter int          CLR_CYCLES   = 2,
  parameter int unsigned STEP_TIMEOUT = 28'd125000000,
  parameter int          TO_W         = 28
) (
  input logic               clk,
  input logic               rst,
  counter_run_ctrl_if.slave bus
);

  localparam int              CLR_W    = $clog2(CLR_CYCLES + 1);
  localparam logic [TO_W-1:0] WD_LAST  = TO_W'(STEP_TIMEOUT - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  // Button vector order: {clear, stop, start, step}, highest priority first.
  logic [3:0] btn;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] hist;
  logic [3:0] cmd;

  state_t           st;
  state_t           nxt;
  logic [TO_W-1:0]  wd;
  logic [CLR_W-1:0] clr_cnt;
  logic [3:0]       step_ref;
  logic             at_limit;
  logic             done_nxt;
  logic             err_nxt;

  assign btn      = {bus.clear_btn, bus.stop_btn, bus.start_btn, bus.step_btn};
  assign cmd      = sync2 & ~hist;
  assign at_limit = (bus.limit != 4'd0) && (bus.count_in == bus.limit);

  // Synchronise the buttons and keep one cycle of history for rising-edge detect;
  // everything resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      hist  <= 4'hF;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Next-state selection with command priority clear > stop > start > step.
  always_comb begin
    nxt      = st;
    done_nxt = 1'b0;
    err_nxt  = 1'b0;
    unique case (st)
      IDLE: begin
        if (cmd[3]) begin
          nxt = CLEAR;
        end else if (!cmd[2]) begin
          if (cmd[1]) begin
            if (!at_limit) nxt = RUN;
          end else if (cmd[0]) begin
            nxt = STEP;
          end
        end
      end
      RUN: begin
        if (cmd[3]) begin
          nxt = CLEAR;
        end else if (cmd[2]) begin
          nxt = IDLE;
        end else if (at_limit) begin
          nxt      = IDLE;
          done_nxt = 1'b1;
        end
      end
      STEP: begin
        if (cmd[3]) begin
          nxt = CLEAR;
        end else if (cmd[2]) begin
          nxt = IDLE;
        end else if (bus.count_in != step_ref) begin
          nxt = IDLE;
        end else if (wd == WD_LAST) begin
          nxt     = IDLE;
          err_nxt = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt == CLR_LAST) nxt = IDLE;
      end
    endcase
  end

  // State register with outputs decoded from the next state, plus the step
  // reference, the saturating step watchdog and the clear-length counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      bus.cnt_en   <= 1'b0;
      bus.cnt_clr  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.step_err <= 1'b0;
      bus.state    <= 2'd0;
      wd           <= '0;
      clr_cnt      <= '0;
      step_ref     <= 4'd0;
    end else begin
      st           <= nxt;
      bus.cnt_en   <= (nxt == RUN) || (nxt == STEP);
      bus.cnt_clr  <= (nxt == CLEAR);
      bus.busy     <= (nxt != IDLE);
      bus.done     <= done_nxt;
      bus.step_err <= err_nxt;
      bus.state    <= nxt;
      if ((st != STEP) && (nxt == STEP)) step_ref <= bus.count_in;
      if ((st == STEP) && (nxt == STEP)) begin
        if (wd != '1) wd <= wd + TO_W'(1);
      end else begin
        wd <= '0;
      end
      if ((st == CLEAR) && (nxt == CLEAR)) clr_cnt <= clr_cnt + CLR_W'(1);
      else                                 clr_cnt <= '0;
    end
  end

endmodule
